// File: rtl/fsm_w.sv
// Washing-machine program sequencer: door lock, valves, motor, soap handling and remaining-time display.
// Latency: a start or soap event takes effect on the next clock edge; power loss and reset force IDLE on the next edge.
// Backpressure: none; SOAP_WAIT stalls the program until detergent is present, and every other phase runs for a fixed count.
module fsm_w (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic [2:0] program_selection,
    input  logic       start,
    input  logic       doorclosed,
    input  logic       soap,
    output logic       valve_in_cold,
    output logic       valve_in_hot,
    output logic       valve_out,
    output logic [1:0] motor,
    output logic [7:0] timer_display,
    output logic       program_done,
    output logic       soap_warning,
    output logic       soap_in,
    output logic       lockDoor
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SOAP_WAIT  = 4'd1,
        FILL       = 4'd2,
        WASH       = 4'd3,
        DRAIN      = 4'd4,
        RINSE_FILL = 4'd5,
        RINSE      = 4'd6,
        SPIN       = 4'd7,
        DONE       = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PROG_COLD      = 2'd0,
        PROG_HOT       = 2'd1,
        PROG_RINSE_DRY = 2'd2,
        PROG_ONLY_DRY  = 2'd3
    } prog_t;

    localparam logic [1:0] MOTOR_OFF     = 2'b00;
    localparam logic [1:0] MOTOR_AGITATE = 2'b01;
    localparam logic [1:0] MOTOR_SPIN    = 2'b10;

    state_t     current_state;
    state_t     next_state;
    prog_t      prog_q;
    prog_t      prog_d;
    logic [7:0] phase_cnt;
    logic [7:0] phase_d;
    logic [7:0] timer_q;
    logic [7:0] timer_d;
    logic       start_ok;
    state_t     start_target;
    logic [7:0] start_total;

    // Value the phase counter takes on entering a state: the phase length
    // minus one, so the counter reads zero on the phase's final cycle.
    // Untimed states just park the counter at zero.
    function automatic logic [7:0] phase_load(input state_t s);
        logic [7:0] v;
        v = 8'd0;
        case (s)
            FILL:       v = 8'd9;
            WASH:       v = 8'd29;
            DRAIN:      v = 8'd9;
            RINSE_FILL: v = 8'd9;
            RINSE:      v = 8'd19;
            SPIN:       v = 8'd19;
            default:    v = 8'd0;
        endcase
        return v;
    endfunction

    // The shorter programs enter the wash sequence part-way through, so a
    // single successor chain serves all four programs.
    function automatic state_t phase_next(input state_t s);
        state_t n;
        n = DONE;
        case (s)
            FILL:       n = WASH;
            WASH:       n = DRAIN;
            DRAIN:      n = RINSE_FILL;
            RINSE_FILL: n = RINSE;
            RINSE:      n = SPIN;
            SPIN:       n = DONE;
            default:    n = DONE;
        endcase
        return n;
    endfunction

    // A start counts only with the door shut and one of the four defined programs selected.
    assign start_ok = start & doorclosed & ~program_selection[2];

    // Entry state and displayed total for the program being requested.
    always_comb begin
        start_target = IDLE;
        start_total  = 8'd0;
        case (program_selection[1:0])
            2'd0, 2'd1: begin
                start_target = soap ? FILL : SOAP_WAIT;
                start_total  = 8'd100;
            end
            2'd2: begin
                start_target = RINSE_FILL;
                start_total  = 8'd50;
            end
            default: begin
                start_target = SPIN;
                start_total  = 8'd20;
            end
        endcase
    end

    // State, program latch, phase counter and display register; reset and power loss clear everything.
    always_ff @(posedge clk) begin
        if (rst || !power) begin
            current_state <= IDLE;
            prog_q        <= PROG_COLD;
            phase_cnt     <= 8'd0;
            timer_q       <= 8'd0;
        end else begin
            current_state <= next_state;
            prog_q        <= prog_d;
            phase_cnt     <= phase_d;
            timer_q       <= timer_d;
        end
    end

    // Next-state, phase timing and display countdown.
    always_comb begin
        next_state = current_state;
        prog_d     = prog_q;
        phase_d    = phase_cnt;
        timer_d    = timer_q;
        case (current_state)
            IDLE, DONE: begin
                timer_d = 8'd0;
                phase_d = 8'd0;
                if (start_ok) begin
                    next_state = start_target;
                    prog_d     = prog_t'(program_selection[1:0]);
                    phase_d    = phase_load(start_target);
                    timer_d    = start_total;
                end
            end
            SOAP_WAIT: begin
                // Display holds while waiting; only soap is watched here.
                if (soap) begin
                    next_state = FILL;
                    phase_d    = phase_load(FILL);
                end
            end
            FILL, WASH, DRAIN, RINSE_FILL, RINSE, SPIN: begin
                timer_d = (timer_q != 8'd0) ? timer_q - 8'd1 : 8'd0;
                if (phase_cnt == 8'd0) begin
                    next_state = phase_next(current_state);
                    phase_d    = phase_load(phase_next(current_state));
                    if (phase_next(current_state) == DONE) begin
                        timer_d = 8'd0;
                    end
                end else begin
                    phase_d = phase_cnt - 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
                phase_d    = 8'd0;
                timer_d    = 8'd0;
            end
        endcase
    end

    // Actuator and status decode; each state drives at most one valve group,
    // so the fill valves never overlap each other or the drain.
    always_comb begin
        valve_in_cold = 1'b0;
        valve_in_hot  = 1'b0;
        valve_out     = 1'b0;
        motor         = MOTOR_OFF;
        program_done  = 1'b0;
        soap_warning  = 1'b0;
        soap_in       = 1'b0;
        lockDoor      = 1'b0;
        case (current_state)
            SOAP_WAIT: begin
                soap_warning = 1'b1;
                lockDoor     = 1'b1;
            end
            FILL: begin
                valve_in_cold = (prog_q == PROG_COLD);
                valve_in_hot  = (prog_q == PROG_HOT);
                soap_in       = 1'b1;
                lockDoor      = 1'b1;
            end
            WASH, RINSE: begin
                motor    = MOTOR_AGITATE;
                lockDoor = 1'b1;
            end
            DRAIN: begin
                valve_out = 1'b1;
                lockDoor  = 1'b1;
            end
            RINSE_FILL: begin
                valve_in_cold = 1'b1;
                lockDoor      = 1'b1;
            end
            SPIN: begin
                motor     = MOTOR_SPIN;
                valve_out = 1'b1;
                lockDoor  = 1'b1;
            end
            DONE: begin
                program_done = 1'b1;
            end
            default: begin
                lockDoor = 1'b0;
            end
        endcase
    end

    assign timer_display = timer_q;

endmodule

// File: tb/tb_fsm_w.sv
// Directed bench for fsm_w: every program, soap wait, rejected starts, mid-program input changes, power and reset aborts.
// Latency: inputs change 1ns after a rising edge; outputs are checked 1ns after the following edge.
// Backpressure: none; all scenarios run for a fixed number of cycles.
module tb_fsm_w;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic [2:0] program_selection;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic       valve_in_cold;
    logic       valve_in_hot;
    logic       valve_out;
    logic [1:0] motor;
    logic [7:0] timer_display;
    logic       program_done;
    logic       soap_warning;
    logic       soap_in;
    logic       lockDoor;

    int n_tests = 0;
    int n_fail  = 0;

    // State codes as probed on current_state.
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SOAP_WAIT  = 4'd1;
    localparam logic [3:0] S_FILL       = 4'd2;
    localparam logic [3:0] S_WASH       = 4'd3;
    localparam logic [3:0] S_DRAIN      = 4'd4;
    localparam logic [3:0] S_RINSE_FILL = 4'd5;
    localparam logic [3:0] S_RINSE      = 4'd6;
    localparam logic [3:0] S_SPIN       = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    // Output pattern: {cold, hot, out, motor[1:0], done, warn, soap_in, lock}
    localparam logic [8:0] P_IDLE      = 9'b0_0_0_00_0_0_0_0;
    localparam logic [8:0] P_SOAP_WAIT = 9'b0_0_0_00_0_1_0_1;
    localparam logic [8:0] P_FILL_COLD = 9'b1_0_0_00_0_0_1_1;
    localparam logic [8:0] P_FILL_HOT  = 9'b0_1_0_00_0_0_1_1;
    localparam logic [8:0] P_AGITATE   = 9'b0_0_0_01_0_0_0_1;
    localparam logic [8:0] P_DRAIN     = 9'b0_0_1_00_0_0_0_1;
    localparam logic [8:0] P_RFILL     = 9'b1_0_0_00_0_0_0_1;
    localparam logic [8:0] P_SPIN      = 9'b0_0_1_10_0_0_0_1;
    localparam logic [8:0] P_DONE      = 9'b0_0_0_00_1_0_0_0;

    always #5 clk = ~clk;

    fsm_w dut (
        .clk               (clk),
        .rst               (rst),
        .power             (power),
        .program_selection (program_selection),
        .start             (start),
        .doorclosed        (doorclosed),
        .soap              (soap),
        .valve_in_cold     (valve_in_cold),
        .valve_in_hot      (valve_in_hot),
        .valve_out         (valve_out),
        .motor             (motor),
        .timer_display     (timer_display),
        .program_done      (program_done),
        .soap_warning      (soap_warning),
        .soap_in           (soap_in),
        .lockDoor          (lockDoor)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {valve_in_cold, valve_in_hot, valve_out, motor, program_done,
                soap_warning, soap_in, lockDoor};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check state, outputs and display once per cycle for n cycles, the display counting down from t0.
    task automatic phase(input string tag, input logic [3:0] st, input int n,
                         input int t0, input logic [8:0] pat);
        for (int i = 0; i < n; i++) begin
            check({tag, "_state"}, 32'(dut.current_state), 32'(st));
            check({tag, "_outs"}, 32'(outs()), 32'(pat));
            check({tag, "_timer"}, 32'(timer_display), 32'(t0 - i));
            step();
        end
    endtask

    // Check a steady state with a fixed display value for n cycles.
    task automatic hold(input string tag, input logic [3:0] st, input int n,
                        input int tv, input logic [8:0] pat);
        for (int i = 0; i < n; i++) begin
            check({tag, "_state"}, 32'(dut.current_state), 32'(st));
            check({tag, "_outs"}, 32'(outs()), 32'(pat));
            check({tag, "_timer"}, 32'(timer_display), 32'(tv));
            step();
        end
    endtask

    task automatic request(input logic [2:0] prog);
        program_selection = prog;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        power = 1'b0;
        program_selection = 3'd0;
        start = 1'b0;
        doorclosed = 1'b1;
        soap = 1'b1;
        step();
        step();
        rst = 1'b0;
        power = 1'b1;
        hold("reset", S_IDLE, 1, 0, P_IDLE);

        // Rejected starts: door open, then invalid program.
        doorclosed = 1'b0;
        request(3'd0);
        hold("rej_door", S_IDLE, 1, 0, P_IDLE);
        doorclosed = 1'b1;
        request(3'd7);
        hold("rej_prog", S_IDLE, 1, 0, P_IDLE);

        // Cold wash, 100 cycles end to end.
        request(3'd0);
        phase("cold_fill", S_FILL, 10, 100, P_FILL_COLD);
        phase("cold_wash", S_WASH, 30, 90, P_AGITATE);
        phase("cold_drain", S_DRAIN, 10, 60, P_DRAIN);
        phase("cold_rfill", S_RINSE_FILL, 10, 50, P_RFILL);
        phase("cold_rinse", S_RINSE, 20, 40, P_AGITATE);
        phase("cold_spin", S_SPIN, 20, 20, P_SPIN);
        hold("cold_done", S_DONE, 3, 0, P_DONE);

        // Hot wash from DONE; inputs disturbed mid-program must have no effect.
        request(3'd1);
        phase("hot_fill", S_FILL, 10, 100, P_FILL_HOT);
        doorclosed = 1'b0;
        start = 1'b1;
        soap = 1'b0;
        program_selection = 3'd3;
        phase("hot_wash", S_WASH, 30, 90, P_AGITATE);
        phase("hot_drain", S_DRAIN, 10, 60, P_DRAIN);
        phase("hot_rfill", S_RINSE_FILL, 10, 50, P_RFILL);
        phase("hot_rinse", S_RINSE, 20, 40, P_AGITATE);
        doorclosed = 1'b1;
        start = 1'b0;
        soap = 1'b1;
        phase("hot_spin", S_SPIN, 20, 20, P_SPIN);
        hold("hot_done", S_DONE, 1, 0, P_DONE);

        // Rinse-dry and only-dry.
        request(3'd2);
        phase("rd_rfill", S_RINSE_FILL, 10, 50, P_RFILL);
        phase("rd_rinse", S_RINSE, 20, 40, P_AGITATE);
        phase("rd_spin", S_SPIN, 20, 20, P_SPIN);
        hold("rd_done", S_DONE, 1, 0, P_DONE);
        request(3'd3);
        phase("od_spin", S_SPIN, 20, 20, P_SPIN);
        hold("od_done", S_DONE, 1, 0, P_DONE);

        // No soap: wait with display held, then fill once soap appears.
        soap = 1'b0;
        request(3'd0);
        hold("sw_wait", S_SOAP_WAIT, 4, 100, P_SOAP_WAIT);
        soap = 1'b1;
        step();
        phase("sw_fill", S_FILL, 10, 100, P_FILL_COLD);
        phase("sw_wash", S_WASH, 5, 90, P_AGITATE);

        // Power loss mid-wash, then starts ignored while unpowered.
        power = 1'b0;
        step();
        hold("pwr_off", S_IDLE, 1, 0, P_IDLE);
        request(3'd0);
        hold("pwr_off_start", S_IDLE, 1, 0, P_IDLE);

        // Reset mid-wash, with start held to show reset wins.
        power = 1'b1;
        request(3'd0);
        phase("rst_fill", S_FILL, 10, 100, P_FILL_COLD);
        phase("rst_wash", S_WASH, 3, 90, P_AGITATE);
        rst = 1'b1;
        start = 1'b1;
        step();
        hold("rst_abort", S_IDLE, 1, 0, P_IDLE);
        rst = 1'b0;
        start = 1'b0;
        step();
        hold("rst_after", S_IDLE, 1, 0, P_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_w.md
FSM_W -- requirements
Module: fsm_w

Interface
REQ-001 Clock and reset SHALL be a single clock and a synchronous, active-high reset.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-002 Control inputs SHALL be:
- power  in  1  0 = machine off
- program_selection  in  3  000 COLD_WASH, 001 HOT_WASH, 010 RINSE_DRY, 011 ONLY_DRY, others invalid
- start  in  1  start request, sampled each cycle
- doorclosed  in  1  1 = door shut
- soap  in  1  1 = detergent present
REQ-003 Actuator and status outputs SHALL be:
- valve_in_cold  out  1  cold fill valve
- valve_in_hot  out  1  hot fill valve
- valve_out  out  1  drain valve
- motor  out  2  00 off, 01 agitate, 10 spin, 11 never driven
REQ-004 Display outputs SHALL be:
- timer_display  out  8  remaining program cycles
- program_done  out  1  program finished
- soap_warning  out  1  wash waiting for soap
- soap_in  out  1  detergent dispense
- lockDoor  out  1  door locked
REQ-005 The state SHALL be held in a 4-bit register named current_state, which benches probe.

Function
REQ-006 States and their outputs SHALL be as follows (all unlisted outputs 0):
- IDLE: all outputs 0
- SOAP_WAIT: soap_warning=1, lockDoor=1
- FILL: 10 cycles; valve_in_cold=1 (COLD_WASH) or valve_in_hot=1 (HOT_WASH); soap_in=1
- WASH: 30 cycles; motor=01
- DRAIN: 10 cycles; valve_out=1
- RINSE_FILL: 10 cycles; valve_in_cold=1
- RINSE: 20 cycles; motor=01
- SPIN: 20 cycles; motor=10, valve_out=1
- DONE: program_done=1
REQ-007 lockDoor SHALL be 1 in every state except IDLE and DONE.
REQ-008 In IDLE or DONE, start=1 with doorclosed=1 and a valid program SHALL latch program_selection and move on the next edge:
- COLD_WASH/HOT_WASH: to FILL if soap=1, otherwise to SOAP_WAIT
- RINSE_DRY: to RINSE_FILL
- ONLY_DRY: to SPIN
REQ-009 A start with doorclosed=0 or an invalid program SHALL be ignored; the state is unchanged.
REQ-010 SOAP_WAIT SHALL go to FILL on the first cycle soap=1 and SHALL wait indefinitely otherwise.
REQ-011 Phase sequences SHALL be:
- wash programs: FILL, WASH, DRAIN, RINSE_FILL, RINSE, SPIN, DONE
- RINSE_DRY: RINSE_FILL, RINSE, SPIN, DONE
- ONLY_DRY: SPIN, DONE
REQ-012 Each phase SHALL last exactly its listed cycle count, timed by a phase counter that reloads on every state entry.
REQ-013 Once running, start, program_selection, doorclosed and soap SHALL be ignored; SOAP_WAIT still samples soap.
REQ-014 On an accepted start, timer_display SHALL load the program total:
- wash: 100
- RINSE_DRY: 50
- ONLY_DRY: 20
REQ-015 timer_display SHALL decrement by 1 each cycle in FILL..SPIN, SHALL hold in SOAP_WAIT, SHALL be 0 in IDLE and DONE, and SHALL never wrap below 0.
REQ-016 DONE SHALL persist until a new accepted start; program_done SHALL stay 1 throughout DONE.
REQ-017 power=0 SHALL, on the next edge, force IDLE with all outputs and counters 0, from any state. While power=0 the state SHALL remain IDLE.
REQ-018 The two fill valves SHALL never be 1 together; no fill valve SHALL be 1 together with valve_out.

Reset
REQ-019 rst=1 on a rising edge SHALL force IDLE with every output 0 and all counters 0, regardless of power or the current state, including mid-program.
REQ-020 rst SHALL take priority over power and start.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Cold wash: rst, then soap=1, COLD_WASH start one cycle -> FILL with valve_in_cold=1, soap_in=1, lockDoor=1, timer_display=100. Then WASH (motor=01), DRAIN, RINSE_FILL, RINSE, SPIN (motor=10, valve_out=1). DONE 100 cycles after start with program_done=1, lockDoor=0.
- No soap: soap=0, COLD_WASH start -> SOAP_WAIT, soap_warning=1, timer_display held at 100. Set soap=1 -> FILL next cycle, soap_warning=0.
- Hot wash: soap=1, program 001 from DONE -> valve_in_hot=1, valve_in_cold=0 for 10 cycles; DONE after 100 cycles.
- Rinse-dry: program 010 -> RINSE_FILL, timer_display=50; DONE after 50 cycles. Only-dry: program 011 -> SPIN 20 cycles, then DONE.
- Rejected starts: start with doorclosed=0 or program 111 -> stays IDLE, all outputs 0. Toggling doorclosed mid-program -> no effect, lockDoor stays 1.
- Abort: rst=1 or power=0 during WASH -> IDLE next edge, motor=00, timer_display=0, lockDoor=0.
